action_control_sequencer: RTL

ACTION_CONTROL_SEQUENCER -- requirements
Module: action_control_sequencer

---
 rtl/action_control_sequencer_pkg.sv | 17 +
 rtl/action_control_sequencer_counter.sv | 35 +++
 rtl/action_control_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/action_control_sequencer_pkg.sv
// Shared state encoding and default parameter values for the action control sequencer.
package action_control_sequencer_pkg;

  localparam int unsigned DEF_RST_REQ_CYCLES  = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 1023;
  localparam int unsigned DEF_COUNTER_SIZE    = 10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RST_REQ  = 3'd1,
    ST_RST_WAIT = 3'd2,
    ST_RUN      = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERROR    = 3'd5
  } state_e;

endpackage

// File: rtl/action_control_sequencer_counter.sv
// Loadable down-counter shared between the reset-pulse width and the reset-done timeout.
module action_control_sequencer_counter #(
  parameter int unsigned Width = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] count_q;
  logic [Width-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/action_control_sequencer.sv
// Start handshake, downstream reset request/wait with timeout, then kernel run until halt.
module action_control_sequencer
  import action_control_sequencer_pkg::*;
#(
  parameter int unsigned RstReqCycles  = DEF_RST_REQ_CYCLES,
  parameter int unsigned TimeoutCycles = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CounterSize   = DEF_COUNTER_SIZE
) (
  input  logic clk,
  input  logic reset,
  input  logic apStart,
  output logic apReady,
  output logic apIdle,
  output logic apDone,
  output logic donutRstReq,
  input  logic donutRstDone,
  output logic actionGo,
  input  logic actionHalt,
  output logic errTimeout,
  input  logic errClear
);

  // The pulse phase loads width-1 so the request stays high for exactly RstReqCycles cycles.
  localparam logic [CounterSize-1:0] RstReqLoad  = CounterSize'(RstReqCycles - 1);
  localparam logic [CounterSize-1:0] TimeoutLoad = CounterSize'(TimeoutCycles);

  state_e                 state_q, state_d;
  logic                   cnt_load, cnt_dec, cnt_zero;
  logic [CounterSize-1:0] cnt_load_val;
  logic                   ap_ready_q, ap_idle_q, ap_done_q;
  logic                   rst_req_q, action_go_q, err_timeout_q;

  action_control_sequencer_counter #(
    .Width(CounterSize)
  ) u_counter (
    .clk       (clk),
    .reset     (reset),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .dec_i     (cnt_dec),
    .zero_o    (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (apStart) begin
          state_d      = ST_RST_REQ;
          cnt_load     = 1'b1;
          cnt_load_val = RstReqLoad;
        end
      end
      ST_RST_REQ: begin
        if (cnt_zero) begin
          state_d      = ST_RST_WAIT;
          cnt_load     = 1'b1;
          cnt_load_val = TimeoutLoad;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RST_WAIT: begin
        // A done arriving on the counter-zero edge still counts as success.
        if (donutRstDone) begin
          state_d = ST_RUN;
        end else if (cnt_zero) begin
          state_d = ST_ERROR;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RUN: begin
        if (actionHalt) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERROR: begin
        if (errClear) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ap_ready_q    <= 1'b0;
      ap_idle_q     <= 1'b1;
      ap_done_q     <= 1'b0;
      rst_req_q     <= 1'b0;
      action_go_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ap_ready_q    <= (state_q == ST_IDLE) && (state_d == ST_RST_REQ);
      ap_idle_q     <= (state_d == ST_IDLE);
      ap_done_q     <= (state_d == ST_DONE);
      rst_req_q     <= (state_d == ST_RST_REQ);
      action_go_q   <= (state_d == ST_RUN);
      err_timeout_q <= (state_d == ST_ERROR);
    end
  end

  assign apReady     = ap_ready_q;
  assign apIdle      = ap_idle_q;
  assign apDone      = ap_done_q;
  assign donutRstReq = rst_req_q;
  assign actionGo    = action_go_q;
  assign errTimeout  = err_timeout_q;

endmodule
